// File: rtl/cpu_pkg.sv
// Shared types for the MEM-stage data memory responder: FSM states, latched
// request record and the optional misalignment rule.
package cpu_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

  localparam int DMEM_LANES = 4;

  // Full words and loads need addr[1:0]==0; halfword stores need addr[0]==0.
  function automatic logic dmem_misaligned(input logic       write,
                                           input logic [1:0] lsb,
                                           input logic [3:0] be);
    logic word_like;
    logic half;
    word_like = !write || (be == 4'hF);
    half      = write && ((be == 4'h3) || (be == 4'hC));
    return (word_like && (lsb != 2'b00)) || (half && lsb[0]);
  endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// Combinational byte-lane merge: each set enable takes the store byte,
// otherwise the old word's byte is kept.
module dmem_byte_merge #(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0][7:0] old_word,
  input  logic [NUM_LANES-1:0][7:0] wdata,
  input  logic [NUM_LANES-1:0]      be,
  output logic [NUM_LANES-1:0][7:0] merged
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign merged[i] = be[i] ? wdata[i] : old_word[i];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder for the MEM stage: one outstanding access,
// fixed latency, stall to hazard control. Optional macro DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_t state, state_nxt;
  logic [3:0]  cnt;
  dmem_req_t   req_q;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic          out_of_range;
  logic          acc_err;
  logic          access;
  logic          do_write;
  logic [31:0]   merged;
  logic          unused_ok;

  assign word_idx     = req_q.addr[AW+1:2];
  assign out_of_range = |req_q.addr[31:AW+2];
  assign unused_ok    = ^req_q.addr[1:0];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign acc_err = out_of_range | dmem_misaligned(req_q.write, req_q.addr[1:0], req_q.be);
`else
  assign acc_err = out_of_range;
`endif

  assign access   = (state == WAIT) && (cnt == 4'd0);
  assign do_write = access && req_q.write && !acc_err && (|req_q.be);

  dmem_byte_merge #(.NUM_LANES(DMEM_LANES)) u_merge (
    .old_word (mem[word_idx]),
    .wdata    (req_q.wdata),
    .be       (req_q.be),
    .merged   (merged)
  );

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign stall      = ((state == IDLE) && req_valid) || (state == WAIT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter loads LATENCY so the access edge is accept+LATENCY+1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_q      <= '0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          req_q <= '{write: req_write, addr: req_addr, wdata: req_wdata, be: req_be};
          cnt   <= 4'(LATENCY);
        end
        WAIT: if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          resp_err   <= acc_err;
          resp_rdata <= (req_q.write || acc_err) ? 32'd0 : mem[word_idx];
        end
        RESP: begin
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Array is not reset; a reset edge never commits a pending store.
  always_ff @(posedge clock) begin
    if (do_write && !reset) mem[word_idx] <= merged;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder against a transaction-level memory model,
// plus literal checks for the directed scenarios.
module tb_dmem_responder;

  localparam int L = 2;
  localparam int D = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be    = 4'd0;
  logic        req_ready, resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH_WORDS(D), .LATENCY(L)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .stall      (stall)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one transaction in flight, k = edges since acceptance.
  logic [31:0] mem_m [int];
  int          n = 0;
  bit          busy = 0;
  int          k = 0;
  int          acc_edge = 0;
  int          acc_cnt = 0;
  logic [29:0] m_idx;
  int          e_idx;
  logic [31:0] e_rdata, e_new, e_old;
  bit          e_err, e_commit;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      busy = 0;
      k    = 0;
    end else begin
      n++;
      if (!busy) begin
        if (req_valid) begin
          busy = 1; k = 0; acc_edge = n; acc_cnt++;
          m_idx = req_addr[31:2];
          e_err = (m_idx >= 30'(D));
`ifdef DMEM_MISALIGN_CHECK_EN
          if (req_addr[1:0] != 2'b00 && (!req_write || req_be == 4'hF)) e_err = 1;
          if (req_write && (req_be == 4'h3 || req_be == 4'hC) && req_addr[0]) e_err = 1;
`endif
          e_idx = e_err ? 0 : int'(m_idx);
          e_old = mem_m.exists(e_idx) ? mem_m[e_idx] : 32'd0;
          e_new = e_old;
          for (int b = 0; b < 4; b++)
            if (req_be[b]) e_new[8*b +: 8] = req_wdata[8*b +: 8];
          e_commit = req_write && !e_err && (req_be != 4'd0);
          e_rdata  = (req_write || e_err) ? 32'd0 : e_old;
        end
      end else begin
        k++;
        if (k == L + 1 && e_commit) mem_m[e_idx] = e_new;
        if (k == L + 2) busy = 0;
      end
    end
  end

  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;
  int          last_resp_edge = 0;
  bit          x_resp, x_wait;

  always @(negedge clock) begin
    x_resp = busy && (k == L + 1);
    x_wait = busy && (k <= L);
    check("req_ready", 32'(req_ready), 32'(!busy));
    check("stall", 32'(stall), 32'((!busy && req_valid) || x_wait));
    check("resp_valid", 32'(resp_valid), 32'(x_resp));
    check("resp_rdata", resp_rdata, x_resp ? e_rdata : 32'd0);
    check("resp_err", 32'(resp_err), x_resp ? 32'(e_err) : 32'd0);
    if (resp_valid) begin
      last_rdata     = resp_rdata;
      last_err       = resp_err;
      last_resp_edge = n;
    end
  end

  task automatic req(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input bit hold);
    int start;
    int t;
    start = acc_cnt;
    t = 0;
    @(posedge clock); #1;
    req_write = w; req_addr = a; req_wdata = d; req_be = b; req_valid = 1'b1;
    while (acc_cnt == start && t < 40) begin
      @(posedge clock); #1;
      t++;
    end
    check("accept", 32'(acc_cnt - start), 32'd1);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 40) begin
      @(posedge clock); #1;
      t++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic load_chk(input string name, input logic [31:0] a,
                          input logic [31:0] exp_d, input bit exp_e);
    req(0, a, 32'd0, 4'h0, 0);
    wait_idle();
    check({name, "_rdata"}, last_rdata, exp_d);
    check({name, "_err"}, 32'(last_err), 32'(exp_e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  int e1, e2;

  initial begin
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      req(1, 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 0);
      wait_idle();
    end

    // Store then load word 0x10; response lands 3 edges after acceptance.
    req(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
    wait_idle();
    check("store_latency", 32'(last_resp_edge - acc_edge), 32'd3);
    load_chk("t1_load", 32'h10, 32'hDEAD_BEEF, 0);
    check("load_latency", 32'(last_resp_edge - acc_edge), 32'd3);

    // Byte-lane merge and be=0 store.
    req(1, 32'h20, 32'h1122_3344, 4'hF, 0); wait_idle();
    req(1, 32'h20, 32'hAABB_CCDD, 4'h5, 0); wait_idle();
    load_chk("t2_merge", 32'h20, 32'h11BB_33DD, 0);
    req(1, 32'h20, 32'h0000_0000, 4'h0, 0); wait_idle();
    check("be0_err", 32'(last_err), 32'd0);
    load_chk("t2_be0", 32'h20, 32'h11BB_33DD, 0);

    // Out of range.
    load_chk("t3_oor", 32'h400, 32'd0, 1);
    load_chk("t3_word0", 32'h0, 32'hA000_0000, 0);

    // Back-to-back with req_valid held: second accept waits for IDLE.
    req(0, 32'h4, 32'd0, 4'h0, 1);
    e1 = acc_edge;
    req(0, 32'h8, 32'd0, 4'h0, 0);
    e2 = acc_edge;
    wait_idle();
    check("t4_accept_gap", 32'(e2 - e1), 32'(L + 3));

    // Reset during WAIT discards the store.
    req(1, 32'h30, 32'h5566_7788, 4'hF, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("t5_resp_valid", 32'(resp_valid), 32'd0);
    check("t5_stall", 32'(stall), 32'd0);
    check("t5_ready", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    load_chk("t5_load", 32'h30, 32'hA000_000C, 0);

`ifdef DMEM_MISALIGN_CHECK_EN
    load_chk("t6_misalign", 32'h13, 32'd0, 1);
`else
    load_chk("t6_misalign", 32'h13, 32'hDEAD_BEEF, 0);
`endif

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h400;
      else a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          (i != 149) && ($urandom_range(0, 1) == 1));
    end
    wait_idle();

    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
